// File: rtl/reflet_vga_bitmap2.sv
// reflet_vga_bitmap2: parametrised VGA timing generator scanning out a reduced-resolution RGB framebuffer.
// Define REFLET_VGA_DOUBLE_BUFFER_EN for front/back banks swapped at the start of vertical blanking.
module reflet_vga_bitmap2 #(
    parameter int color_depth   = 2,
    parameter int clk_freq      = 100000000,
    parameter int pixel_freq    = 25000000,
    parameter int bit_reduction = 3,
    parameter int h_visible     = 640,
    parameter int h_front       = 16,
    parameter int h_sync_width  = 96,
    parameter int h_back        = 48,
    parameter int v_visible     = 480,
    parameter int v_front       = 10,
    parameter int v_sync_width  = 2,
    parameter int v_back        = 33,
    parameter bit sync_active_high = 1'b0,
    parameter bit ram_resetable    = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           write_bitmap,
    input  logic [$clog2(h_visible >> bit_reduction)-1:0] h_pixel,
    input  logic [$clog2(v_visible >> bit_reduction)-1:0] v_pixel,
    input  logic [color_depth-1:0]                         R_in,
    input  logic [color_depth-1:0]                         G_in,
    input  logic [color_depth-1:0]                         B_in,
    input  logic                                           swap_req,
    output logic                                           busy,
    output logic                                           swap_done,
    output logic [color_depth-1:0]                         R_out,
    output logic [color_depth-1:0]                         G_out,
    output logic [color_depth-1:0]                         B_out,
    output logic                                           h_sync,
    output logic                                           v_sync
);

    localparam int DIV     = (clk_freq / pixel_freq < 1) ? 1 : clk_freq / pixel_freq;
    localparam int DVW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H_TOTAL = h_visible + h_front + h_sync_width + h_back;
    localparam int V_TOTAL = v_visible + v_front + v_sync_width + v_back;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int H_RES   = h_visible >> bit_reduction;
    localparam int V_RES   = v_visible >> bit_reduction;
    localparam int HW      = $clog2(H_RES);
    localparam int VW      = $clog2(V_RES);
    localparam int DEPTH   = H_RES * V_RES;
`ifdef REFLET_VGA_DOUBLE_BUFFER_EN
    localparam int BANKS   = 2;
    localparam bit DB_EN   = 1'b1;
`else
    localparam int BANKS   = 1;
    localparam bit DB_EN   = 1'b0;
`endif
    localparam int WORDS   = DEPTH * BANKS;
    localparam int IW      = $clog2(WORDS);
    localparam int PW      = 3 * color_depth;

    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_VIS    = HCW'(h_visible);
    localparam logic [VCW-1:0] V_VIS    = VCW'(v_visible);
    localparam logic [HCW-1:0] HS_START = HCW'(h_visible + h_front);
    localparam logic [HCW-1:0] HS_END   = HCW'(h_visible + h_front + h_sync_width);
    localparam logic [VCW-1:0] VS_START = VCW'(v_visible + v_front);
    localparam logic [VCW-1:0] VS_END   = VCW'(v_visible + v_front + v_sync_width);
    localparam logic [IW-1:0]  CLR_LAST = IW'(WORDS - 1);

    logic [DVW-1:0] div_q, div_d;
    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;
    logic           vis_p1_q, vis_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic [PW-1:0]  rgb_q, rgb_d;
    logic           h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic           busy_q, busy_d;
    logic [IW-1:0]  clr_addr_q, clr_addr_d;
    logic           pending_q, pending_d, bank_q, bank_d, swap_done_q, swap_done_d;
    logic           tick_s, visible_s, hs_act_s, vs_act_s, swap_fire_s, in_range_s, back_bank_s;
    logic [IW-1:0]  rd_idx_s, wr_idx_s, mem_wa_s;
    logic           mem_we_s;
    logic [PW-1:0]  mem_wd_s, rd_data_q;
    logic [PW-1:0]  fb_mem [WORDS];

    // Next-state logic: pixel divider, beam counters, scan pipeline, clear sequencer, swap control, RAM port mux
    always_comb begin
        div_d       = div_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        busy_d      = busy_q;
        clr_addr_d  = clr_addr_q;
        mem_we_s    = 1'b0;
        mem_wa_s    = '0;
        mem_wd_s    = '0;

        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = '0;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        visible_s = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_act_s  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_act_s  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        // Out-of-picture beam positions would index past the bank, so park the read on word 0
        if (visible_s) begin
            rd_idx_s = IW'(int'(bank_q) * DEPTH + int'(v_cnt_q >> bit_reduction) * H_RES
                           + int'(h_cnt_q >> bit_reduction));
        end else begin
            rd_idx_s = '0;
        end

        vis_p1_d = visible_s;
        hs_p1_d  = hs_act_s;
        vs_p1_d  = vs_act_s;
        rgb_d    = vis_p1_q ? rd_data_q : '0;
        h_sync_d = sync_active_high ? hs_p1_q : ~hs_p1_q;
        v_sync_d = sync_active_high ? vs_p1_q : ~vs_p1_q;

        swap_fire_s = DB_EN && pending_q && tick_s && (h_cnt_q == '0) && (v_cnt_q == V_VIS);
        pending_d   = DB_EN && (swap_req || (pending_q && !swap_fire_s));
        bank_d      = bank_q ^ swap_fire_s;
        swap_done_d = swap_fire_s;

        back_bank_s = DB_EN & ~bank_q;
        in_range_s  = ({1'b0, h_pixel} < (HW + 1)'(H_RES)) && ({1'b0, v_pixel} < (VW + 1)'(V_RES));
        wr_idx_s    = IW'(int'(back_bank_s) * DEPTH + int'(v_pixel) * H_RES + int'(h_pixel));

        // The clear sequencer owns the write port while busy; user writes are dropped
        if (busy_q) begin
            mem_we_s   = 1'b1;
            mem_wa_s   = clr_addr_q;
            mem_wd_s   = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            busy_d     = (clr_addr_q != CLR_LAST);
        end else if (write_bitmap && in_range_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wr_idx_s;
            mem_wd_s = {R_in, G_in, B_in};
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q       <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            vis_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            rgb_q       <= '0;
            h_sync_q    <= ~sync_active_high;
            v_sync_q    <= ~sync_active_high;
            busy_q      <= ram_resetable;
            clr_addr_q  <= '0;
            pending_q   <= 1'b0;
            bank_q      <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            vis_p1_q    <= vis_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            rgb_q       <= rgb_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            busy_q      <= busy_d;
            clr_addr_q  <= clr_addr_d;
            pending_q   <= pending_d;
            bank_q      <= bank_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Framebuffer RAM: single write port, registered read-first read port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            fb_mem[mem_wa_s] <= mem_wd_s;
        end
        rd_data_q <= fb_mem[rd_idx_s];
    end

    assign busy      = busy_q;
    assign swap_done = swap_done_q;
    assign R_out     = rgb_q[PW-1 -: color_depth];
    assign G_out     = rgb_q[2*color_depth-1 -: color_depth];
    assign B_out     = rgb_q[color_depth-1:0];
    assign h_sync    = h_sync_q;
    assign v_sync    = v_sync_q;

endmodule

// File: tb/tb_reflet_vga_bitmap2.sv
// Randomised bench for reflet_vga_bitmap2 on a shrunken screen, compared every clock against
// a frame-level reference model (beam position from elapsed ticks, framebuffer as an int array).
module tb_reflet_vga_bitmap2;

    localparam int CD = 2, BR = 2, DIV = 3;
    localparam int HV = 40, HF = 4, HS = 6, HB = 4;
    localparam int VV = 28, VF = 2, VS = 3, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HRES = HV >> BR, VRES = VV >> BR;
    localparam int DEPTH = HRES * VRES;
    localparam int FRAME = HT * VT * DIV;
`ifdef REFLET_VGA_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int WORDS = DB ? 2 * DEPTH : DEPTH;

    logic clk = 1'b0;
    logic reset, write_bitmap, swap_req;
    logic [3:0] h_pixel;
    logic [2:0] v_pixel;
    logic [CD-1:0] R_in, G_in, B_in, R_out, G_out, B_out;
    logic busy, swap_done, h_sync, v_sync;

    int checks, failures, n;
    int mem_m [WORDS];
    int q_rgb [$];
    int q_hs [$];
    int q_vs [$];
    bit pending_m, bank_m, sd_exp;

    always #5 clk = ~clk;

    reflet_vga_bitmap2 #(
        .color_depth(CD), .clk_freq(75), .pixel_freq(25), .bit_reduction(BR),
        .h_visible(HV), .h_front(HF), .h_sync_width(HS), .h_back(HB),
        .v_visible(VV), .v_front(VF), .v_sync_width(VS), .v_back(VB),
        .sync_active_high(1'b0), .ram_resetable(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .write_bitmap(write_bitmap),
        .h_pixel(h_pixel), .v_pixel(v_pixel),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .swap_req(swap_req),
        .busy(busy), .swap_done(swap_done),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .h_sync(h_sync), .v_sync(v_sync)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
        end
    endtask

    // After a reset edge the two pipeline stages hold blank, sync-inactive values
    task automatic reset_model();
        q_rgb.delete(); q_hs.delete(); q_vs.delete();
        repeat (2) begin
            q_rgb.push_back(0); q_hs.push_back(1); q_vs.push_back(1);
        end
        n = 0; pending_m = 1'b0; bank_m = 1'b0; sd_exp = 1'b0;
    endtask

    // Runs at a negedge: check this cycle's outputs, drive inputs, advance the model by one clk
    task automatic cycle(input bit rst_v, input bit wr, input int hp, input int vp,
                         input int rgb, input bit sw);
        int er, eh, ev, p, h, v;
        bit busy_e, fire;
        er = q_rgb.pop_front(); eh = q_hs.pop_front(); ev = q_vs.pop_front();
        if (er >= 0) check("rgb", {26'd0, R_out, G_out, B_out}, er);
        check("hsync", {31'd0, h_sync}, eh);
        check("vsync", {31'd0, v_sync}, ev);
        busy_e = (n < WORDS);
        check("busy", {31'd0, busy}, {31'd0, busy_e});
        check("swap_done", {31'd0, swap_done}, {31'd0, sd_exp});

        reset = rst_v; write_bitmap = wr; swap_req = sw;
        h_pixel = 4'(hp); v_pixel = 3'(vp);
        {R_in, G_in, B_in} = 6'(rgb);

        p = (n / DIV) % (HT * VT);
        h = p % HT;
        v = p / HT;
        if (h < HV && v < VV) er = mem_m[int'(bank_m) * DEPTH + (v >> BR) * HRES + (h >> BR)];
        else er = 0;
        eh = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
        ev = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;

        if (!rst_v) begin
            reset_model();
        end else begin
            q_rgb.push_back(er); q_hs.push_back(eh); q_vs.push_back(ev);
            fire = DB && pending_m && (n % DIV == DIV - 1) && h == 0 && v == VV;
            sd_exp = fire;
            if (busy_e) mem_m[n] = 0;
            else if (wr && hp < HRES && vp < VRES)
                mem_m[(DB ? int'(!bank_m) : 0) * DEPTH + vp * HRES + hp] = rgb;
            pending_m = DB && (sw || (pending_m && !fire));
            bank_m = bank_m ^ fire;
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        bit wr, sw;
        checks = 0; failures = 0; n = 0;
        reset = 1'b0; write_bitmap = 1'b0; swap_req = 1'b0;
        h_pixel = '0; v_pixel = '0; R_in = '0; G_in = '0; B_in = '0;
        foreach (mem_m[i]) mem_m[i] = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_model();

        // writes attempted while the clear is running must be dropped
        for (int i = 0; i < 30; i++)
            cycle(1'b1, 1'b1, $urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1),
                  $urandom_range(0, 63), 1'b0);
        // reset in the middle of the clear restarts it from address 0
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < WORDS + 5; i++) cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);

        // directed pixel (R=2,G=1,B=0), then out-of-range column and row
        cycle(1'b1, 1'b1, 5, 2, 6'b10_01_00, 1'b0);
        cycle(1'b1, 1'b1, HRES, 2, 63, 1'b0);
        cycle(1'b1, 1'b1, 3, VRES, 63, 1'b0);
        cycle(1'b1, 1'b1, 15, 7, 63, 1'b0);
        for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);

        // random traffic with occasional swap requests, including a double request
        for (int i = 0; i < 3 * FRAME; i++) begin
            wr = ($urandom_range(0, 15) == 0);
            sw = ($urandom_range(0, 1999) == 0) || (i == 1000) || (i == 1003);
            cycle(1'b1, wr, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 63), sw);
        end
        for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
